mesh_port_arbiter: RTL and testbench

Round-robin output-port arbiter for one router node of the mesh. It shares a single outgoing link among `N_IN` input FIFOs (N, S, E, W, local), each of which has already been route-filtered to this output. It pops the granted FIFO, holds the packet in a one-entry output register, and presents it downstream with the mesh `pndng`/`pop` handshake. One instance sits on each output port of a `mesh_gnrtr` router node.

---
 rtl/mesh_arb_pkg.sv | 20 ++
 rtl/mesh_port_arbiter_rr_pick.sv | 35 +++
 rtl/mesh_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mesh_port_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_arb_pkg.sv
// Shared types and constants for the mesh output-port arbiter.
package mesh_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } arb_state_e;

  localparam int unsigned N_IN_DEF      = 5;
  localparam int unsigned PAKG_SIZE_DEF = 32;

  // Input-port indices of a mesh router node.
  localparam int unsigned PORT_N     = 0;
  localparam int unsigned PORT_S     = 1;
  localparam int unsigned PORT_E     = 2;
  localparam int unsigned PORT_W     = 3;
  localparam int unsigned PORT_LOCAL = 4;

endpackage

// File: rtl/mesh_port_arbiter_rr_pick.sv
// rr_pick: rotate-priority encoder. Returns the first requester found
// scanning upward from ptr with wrap-around, as one-hot and as an index.
module rr_pick #(
  parameter int unsigned N  = 5,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] k;
  logic          found;

  assign any = |req;

  // Walk the N positions starting at ptr; the first set request wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = IW'((32'(ptr) + i) % N);
      if (!found && req[k]) begin
        found      = 1'b1;
        gnt_oh[k]  = 1'b1;
        gnt_idx    = k;
      end
    end
  end

endmodule

// File: rtl/mesh_port_arbiter.sv
// mesh_port_arbiter: round-robin arbiter sharing one output link among
// N_IN route-filtered input FIFOs, with a one-entry output register.
// Optional per-input grant counters are compiled in with `define ARB_STATS_EN.
module mesh_port_arbiter
  import mesh_arb_pkg::*;
#(
  parameter int unsigned N_IN      = N_IN_DEF,
  parameter int unsigned PAKG_SIZE = PAKG_SIZE_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_IN-1:0]           pndng_i,
  input  logic [N_IN*PAKG_SIZE-1:0] data_i,
  output logic [N_IN-1:0]           pop_o,
  output logic                      pndng_o,
  output logic [PAKG_SIZE-1:0]      data_o,
  input  logic                      pop_i,
  output logic [N_IN*CNT_W-1:0]     gnt_cnt_o
);

  localparam int unsigned IW = $clog2(N_IN);

  arb_state_e           state_q;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        gnt_q;
  logic [N_IN-1:0]      gnt_oh_q;
  logic [N_IN-1:0]      win_oh;
  logic [IW-1:0]        win_idx;
  logic                 win_any;
  logic                 gnt_live;
  logic [IW-1:0]        ptr_nxt;
  logic [PAKG_SIZE-1:0] data_arr [N_IN];

  rr_pick #(.N(N_IN), .IW(IW)) u_pick (
    .req     (pndng_i),
    .ptr     (ptr_q),
    .gnt_oh  (win_oh),
    .gnt_idx (win_idx),
    .any     (win_any)
  );

  // Unpack the flat head-packet bus into one word per input.
  always_comb begin
    for (int unsigned k = 0; k < N_IN; k++) begin
      data_arr[k] = data_i[k*PAKG_SIZE +: PAKG_SIZE];
    end
  end

  // A grant completes only if the granted FIFO still has its packet; the
  // pop strobe is gated by the live request so a withdrawn request is never popped.
  assign gnt_live = pndng_i[gnt_q];
  assign pop_o    = (state_q == GRANT) ? (gnt_oh_q & pndng_i) : '0;
  assign ptr_nxt  = (gnt_q == IW'(N_IN - 1)) ? '0 : gnt_q + IW'(1);

  // Arbitration FSM with the output register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      gnt_oh_q <= '0;
      pndng_o  <= 1'b0;
      data_o   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_any) begin
            gnt_q    <= win_idx;
            gnt_oh_q <= win_oh;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          if (gnt_live) begin
            data_o  <= data_arr[gnt_q];
            pndng_o <= 1'b1;
            ptr_q   <= ptr_nxt;
            state_q <= HOLD;
          end else begin
            state_q <= IDLE;
          end
        end
        HOLD: begin
          if (pop_i) begin
            pndng_o <= 1'b0;
            if (win_any) begin
              gnt_q    <= win_idx;
              gnt_oh_q <= win_oh;
              state_q  <= GRANT;
            end else begin
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [N_IN];

  // Saturating count of completed grants per input.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned k = 0; k < N_IN; k++) begin
        cnt_q[k] <= '0;
      end
    end else if (state_q == GRANT && gnt_live && cnt_q[gnt_q] != '1) begin
      cnt_q[gnt_q] <= cnt_q[gnt_q] + CNT_W'(1);
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    gnt_cnt_o = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      gnt_cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end
`else
  assign gnt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Self-checking bench for mesh_port_arbiter: directed scenarios plus
// randomized traffic, compared against a transaction-level reference model.
module tb_mesh_port_arbiter;
  import mesh_arb_pkg::*;

  localparam int N  = 5;
  localparam int W  = 32;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      pndng_i;
  logic [N*W-1:0]    data_i;
  logic [N-1:0]      pop_o;
  logic              pndng_o;
  logic [W-1:0]      data_o;
  logic              pop_i;
  logic [N*CW-1:0]   gnt_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mesh_port_arbiter #(.N_IN(N), .PAKG_SIZE(W), .CNT_W(CW)) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .pndng_i   (pndng_i),
    .data_i    (data_i),
    .pop_o     (pop_o),
    .pndng_o   (pndng_o),
    .data_o    (data_o),
    .pop_i     (pop_i),
    .gnt_cnt_o (gnt_cnt_o)
  );

  // Reference model: pending grant target (-1 = none), held packet, pointer.
  int          m_ptr;
  int          m_gnt;
  bit          m_valid;
  logic [W-1:0] m_data;
  int          m_cnt [N];
  int          grants[$];
  int          pop_cyc[$];
  int          cyc;
  bit          use_d2;
  logic [W-1:0] d2_val;

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int off = 0; off < N; off++) begin
      if (req[(ptr + off) % N]) return (ptr + off) % N;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_gnt   = -1;
    m_valid = 1'b0;
    m_data  = '0;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
  endtask

  task automatic check_outputs(input logic [N-1:0] exp_pop);
    check("pop_o", 32'(pop_o), 32'(exp_pop));
    check("pndng_o", 32'(pndng_o), 32'(m_valid));
    check("data_o", data_o, m_data);
    for (int k = 0; k < N; k++) begin
`ifdef ARB_STATS_EN
      check("gnt_cnt", 32'(gnt_cnt_o[k*CW +: CW]), 32'(m_cnt[k]));
`else
      check("gnt_cnt", 32'(gnt_cnt_o[k*CW +: CW]), 32'd0);
`endif
    end
  endtask

  // One clock cycle: drive at negedge, check, advance the model, wait posedge.
  task automatic cycle(input logic [N-1:0] req, input logic pop);
    logic [N-1:0] exp_pop;
    @(negedge clk);
    pndng_i = req;
    pop_i   = pop;
    for (int k = 0; k < N; k++) data_i[k*W +: W] = $urandom();
    if (use_d2) data_i[2*W +: W] = d2_val;
    #1;
    exp_pop = '0;
    if (m_gnt >= 0) begin
      if (req[m_gnt]) exp_pop[m_gnt] = 1'b1;
    end
    check_outputs(exp_pop);
    for (int k = 0; k < N; k++) begin
      if (pop_o[k]) begin
        grants.push_back(k);
        pop_cyc.push_back(cyc);
      end
    end
    if (m_gnt >= 0) begin
      if (req[m_gnt]) begin
        m_valid = 1'b1;
        m_data  = data_i[m_gnt*W +: W];
        m_ptr   = (m_gnt + 1) % N;
        if (m_cnt[m_gnt] < (1 << CW) - 1) m_cnt[m_gnt]++;
      end
      m_gnt = -1;
    end else if (m_valid) begin
      if (pop) begin
        m_valid = 1'b0;
        m_gnt   = pick(req, m_ptr);
      end
    end else begin
      m_gnt = pick(req, m_ptr);
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    pndng_i = '0;
    pop_i   = 1'b0;
    #1;
    model_reset();
    check_outputs('0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    logic [W-1:0] held;
    cyc     = 0;
    use_d2  = 1'b0;
    d2_val  = 32'hA5A5_0001;
    rst_n   = 1'b0;
    pndng_i = '0;
    pop_i   = 1'b0;
    data_i  = '0;
    model_reset();
    #2;
    check("rst_pop_o", 32'(pop_o), 32'd0);
    check("rst_pndng_o", 32'(pndng_o), 32'd0);
    check("rst_data_o", data_o, 32'd0);
    check("rst_gnt_cnt", 32'(gnt_cnt_o[CW-1:0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request on input 2.
    use_d2 = 1'b1;
    grants.delete();
    cycle(5'b00100, 1'b1);
    cycle(5'b00100, 1'b1);
    #1;
    check("single_pndng", 32'(pndng_o), 32'd1);
    check("single_data", data_o, 32'hA5A5_0001);
    check("single_pop_off", 32'(pop_o), 32'd0);
    cycle(5'b00000, 1'b1);
    #1;
    check("single_idle", 32'(pndng_o), 32'd0);
    cycle(5'b00000, 1'b1);
    check("single_npops", 32'(grants.size()), 32'd1);
    check("single_gnt", 32'(grants[0]), 32'd2);
    use_d2 = 1'b0;

    // Fairness: all inputs requesting, consumer always ready.
    do_reset();
    grants.delete();
    pop_cyc.delete();
    for (int i = 0; i < 20; i++) cycle(5'b11111, 1'b1);
    check("fair_npops", 32'(grants.size()), 32'd10);
    for (int i = 0; i < 10 && i < grants.size(); i++) begin
      check("fair_order", 32'(grants[i]), 32'(i % N));
      if (i > 0) check("fair_spacing", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd2);
    end
    #1;
`ifdef ARB_STATS_EN
    for (int k = 0; k < N; k++) check("fair_cnt", 32'(gnt_cnt_o[k*CW +: CW]), 32'd2);
`endif

    // Backpressure: consumer stalls for 20 cycles.
    held = data_o;
    n0   = grants.size();
    for (int i = 0; i < 20; i++) cycle(5'b11111, 1'b0);
    check("bp_no_pop", 32'(grants.size() - n0), 32'd0);
    check("bp_data_stable", data_o, held);
    cycle(5'b11111, 1'b1);
    cycle(5'b11111, 1'b1);
    check("bp_release", 32'(grants.size() - n0), 32'd1);
    check("bp_release_gnt", 32'(grants[$]), 32'd0);
    cycle(5'b00000, 1'b1);
    cycle(5'b00000, 1'b1);

    // Withdrawn request during GRANT.
    n0 = grants.size();
    cycle(5'b00010, 1'b1);
    cycle(5'b00000, 1'b1);
    cycle(5'b00000, 1'b1);
    check("wd_no_pop", 32'(grants.size() - n0), 32'd0);
    check("wd_pndng", 32'(pndng_o), 32'd0);

    // Asynchronous reset while holding a packet.
    cycle(5'b10000, 1'b0);
    cycle(5'b10000, 1'b0);
    #1;
    check("rh_pre_pndng", 32'(pndng_o), 32'd1);
    #2;
    rst_n   = 1'b0;
    pndng_i = '0;
    pop_i   = 1'b0;
    #1;
    check("rh_pndng", 32'(pndng_o), 32'd0);
    check("rh_pop", 32'(pop_o), 32'd0);
    check("rh_data", data_o, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    grants.delete();
    cycle(5'b11111, 1'b1);
    cycle(5'b11111, 1'b1);
    check("rh_ptr_restart", 32'(grants[0]), 32'd0);
    cycle(5'b00000, 1'b1);
    cycle(5'b00000, 1'b1);

    // Wrap-around: serve input 3, then requests {0,4} go 4 then 0.
    do_reset();
    grants.delete();
    cycle(5'b01000, 1'b1);
    cycle(5'b01000, 1'b1);
    for (int i = 0; i < 4; i++) cycle(5'b10001, 1'b1);
    cycle(5'b00000, 1'b1);
    cycle(5'b00000, 1'b1);
    check("wrap_npops", 32'(grants.size()), 32'd3);
    check("wrap_g0", 32'(grants[0]), 32'd3);
    check("wrap_g1", 32'(grants[1]), 32'd4);
    check("wrap_g2", 32'(grants[2]), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
